fnd_scan_decoder: RTL and testbench

Receive-side counterpart of the FND segment encoder. It watches a multiplexed, active-low 7-segment display bus (digit commons plus segment lines), waits for each digit's pattern to be stable, and decodes it back to a 4-bit number. It keeps one register per digit position. Uses: board-level loopback checks and on-chip display readback/self-test.

---
 rtl/fnd_pkg.sv | 51 +++++
 rtl/fnd_seg_decode.sv | 40 ++++
 rtl/fnd_scan_decoder.sv | 130 +++++++++++++
 tb/tb_fnd_scan_decoder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared 7-segment definitions for the FND encoder/decoder pair.
// Segment codes are active-low, bit0=a .. bit6=g.
`default_nettype none

package fnd_pkg;

  localparam int SEG_W = 7;
  localparam int NUM_W = 4;

  localparam logic [NUM_W-1:0] NUM_ERR = 4'hF;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1011000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0011000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HELD  = 2'd2
  } state_t;

  // Encoder-side mapping; anything outside 0-9 drives a dark digit.
  function automatic logic [SEG_W-1:0] seg_encode(input logic [NUM_W-1:0] num);
    logic [SEG_W-1:0] seg;
    case (num)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fnd_seg_decode.sv
// Combinational 7-segment (active-low) to digit decoder.
// Revision: 1.0
`default_nettype none

module fnd_seg_decode
  import fnd_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic [NUM_W-1:0] num,
  output logic             legal,
  output logic             blank
);

  always_comb begin
    num   = NUM_ERR;
    legal = 1'b1;
    blank = 1'b0;
    case (seg)
      SEG_0:     num = 4'd0;
      SEG_1:     num = 4'd1;
      SEG_2:     num = 4'd2;
      SEG_3:     num = 4'd3;
      SEG_4:     num = 4'd4;
      SEG_5:     num = 4'd5;
      SEG_6:     num = 4'd6;
      SEG_7:     num = 4'd7;
      SEG_8:     num = 4'd8;
      SEG_9:     num = 4'd9;
      SEG_BLANK: begin
        num   = 4'd0;
        legal = 1'b0;
        blank = 1'b1;
      end
      default:   legal = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fnd_scan_decoder.sv
// Watches a multiplexed active-low FND bus and commits each stable digit
// pattern into a per-digit result slot.  Revision: 1.0
`default_nettype none

module fnd_scan_decoder
  import fnd_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic [DIGITS-1:0]       i_Com,
  input  logic [SEG_W-1:0]        i_FND,
  output logic [NUM_W*DIGITS-1:0] o_Num,
  output logic [DIGITS-1:0]       o_Valid,
  output logic [DIGITS-1:0]       o_Err,
  output logic                    o_Upd,
  output logic [2:0]              o_UpdIdx
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYC - 1);

  logic [DIGITS-1:0] s_com;
  logic [SEG_W-1:0]  s_fnd;
  logic [7:0]        cnt;
  state_t            state;

  logic              same;
  logic              one_low;
  logic [2:0]        low_idx;
  logic [3:0]        zeros;
  logic [NUM_W-1:0]  dec_num;
  logic              dec_legal;
  logic              dec_blank;
  logic [NUM_W-1:0]  slot_num;
  logic              will_commit;

  fnd_seg_decode u_dec (
    .seg   (s_fnd),
    .num   (dec_num),
    .legal (dec_legal),
    .blank (dec_blank)
  );

  // The incoming sample is compared against the held one, so a change is
  // seen on the same edge it is captured.
  assign same = (i_Com == s_com) && (i_FND == s_fnd);

  always_comb begin
    zeros   = 4'd0;
    low_idx = 3'd0;
    for (int d = 0; d < DIGITS; d++) begin
      if (!s_com[d]) begin
        zeros   = zeros + 4'd1;
        low_idx = 3'(d);
      end
    end
    one_low = (zeros == 4'd1);
  end

  always_comb begin
    slot_num = NUM_ERR;
    if (dec_legal)
      slot_num = dec_num;
    else if (dec_blank)
      slot_num = '0;
  end

  assign will_commit = (state == TRACK) && same && (cnt != CNT_MAX)
                       && ((cnt + 8'd1) == CNT_MAX) && one_low;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      s_com    <= '1;
      s_fnd    <= '1;
      cnt      <= '0;
      state    <= IDLE;
      o_Num    <= '0;
      o_Valid  <= '0;
      o_Err    <= '0;
      o_Upd    <= 1'b0;
      o_UpdIdx <= 3'd0;
    end else begin
      s_com <= i_Com;
      s_fnd <= i_FND;
      o_Upd <= 1'b0;

      case (state)
        IDLE: begin
          cnt   <= '0;
          state <= TRACK;
        end
        TRACK: begin
          if (!same)
            cnt <= '0;
          else if (cnt != CNT_MAX)
            cnt <= cnt + 8'd1;
          if (will_commit)
            state <= HELD;
        end
        HELD: begin
          if (!same) begin
            cnt   <= '0;
            state <= TRACK;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase

      if (will_commit) begin
        o_Upd    <= 1'b1;
        o_UpdIdx <= low_idx;
        for (int d = 0; d < DIGITS; d++) begin
          if (low_idx == 3'(d)) begin
            o_Num[NUM_W*d +: NUM_W] <= slot_num;
            o_Valid[d]              <= dec_legal;
            o_Err[d]                <= !dec_legal && !dec_blank;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fnd_scan_decoder.sv
// Directed self-checking bench for fnd_scan_decoder (DIGITS=4, STABLE_CYC=4).
`default_nettype none

module tb_fnd_scan_decoder;

  logic        clk;
  logic        rst;
  logic [3:0]  com;
  logic [6:0]  fnd;
  logic [15:0] num;
  logic [3:0]  valid;
  logic [3:0]  err;
  logic        upd;
  logic [2:0]  upd_idx;

  int n_checks = 0;
  int n_fail   = 0;
  int n_upd    = 0;
  logic [2:0] idx_log [16];

  fnd_scan_decoder #(.DIGITS(4), .STABLE_CYC(4)) dut (
    .i_Clk    (clk),
    .i_Rst    (rst),
    .i_Com    (com),
    .i_FND    (fnd),
    .o_Num    (num),
    .o_Valid  (valid),
    .o_Err    (err),
    .o_Upd    (upd),
    .o_UpdIdx (upd_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse logger: o_Upd is registered, so mid-cycle sampling sees each pulse once.
  always @(negedge clk) begin
    if (upd) begin
      if (n_upd < 16) idx_log[n_upd] = upd_idx;
      n_upd = n_upd + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic [6:0] f);
    com = c;
    fnd = f;
  endtask

  int base;

  initial begin
    rst = 1'b1;
    com = 4'b1111;
    fnd = 7'b1111111;
    step(2);
    check("reset_num",   32'(num),     32'h0);
    check("reset_valid", 32'(valid),   32'h0);
    check("reset_err",   32'(err),     32'h0);
    check("reset_upd",   32'(upd),     32'h0);
    check("reset_idx",   32'(upd_idx), 32'h0);
    rst = 1'b0;

    // Single digit: commit lands on the 4th edge, pulse lasts one cycle.
    base = n_upd;
    drive(4'b1110, 7'b0100100);
    step(3);
    check("lat_no_upd_early", 32'(upd), 32'h0);
    step(1);
    check("lat_upd",      32'(upd),       32'h1);
    check("lat_idx",      32'(upd_idx),   32'h0);
    check("lat_num0",     32'(num[3:0]),  32'h2);
    check("lat_valid",    32'(valid),     32'b0001);
    check("lat_err",      32'(err),       32'b0000);
    step(2);
    check("lat_upd_drop", 32'(upd), 32'h0);
    check("lat_pulses",   n_upd - base, 1);

    // Full scan of all four digits.
    base = n_upd;
    drive(4'b1110, 7'b1111001); step(5);
    drive(4'b1101, 7'b0011000); step(5);
    drive(4'b1011, 7'b1011000); step(5);
    drive(4'b0111, 7'b0000000); step(5);
    check("scan_num",    32'(num),   32'h8791);
    check("scan_valid",  32'(valid), 32'b1111);
    check("scan_err",    32'(err),   32'b0000);
    check("scan_pulses", n_upd - base, 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("scan_idx%0d", i), 32'(idx_log[base + i]), 32'(i));

    // Glitch after three stable cycles must not commit.
    base = n_upd;
    drive(4'b1011, 7'b0010010); step(3);
    drive(4'b1011, 7'b0110000);
    check("glitch_no_pulse", n_upd - base, 0);
    check("glitch_slot",     32'(num[11:8]), 32'h7);
    step(4);
    check("glitch_commit_num", 32'(num), 32'h8391);
    step(1);
    check("glitch_pulses", n_upd - base, 1);

    // Illegal pattern, then blank, on digit 1.
    drive(4'b1101, 7'b1010101); step(5);
    check("illegal_num",   32'(num),   32'h83F1);
    check("illegal_err",   32'(err),   32'b0010);
    check("illegal_valid", 32'(valid), 32'b1101);
    drive(4'b1101, 7'b1111111); step(5);
    check("blank_num",   32'(num),   32'h8301);
    check("blank_err",   32'(err),   32'b0000);
    check("blank_valid", 32'(valid), 32'b1101);

    // No digit or several digits selected: nothing commits.
    base = n_upd;
    drive(4'b1111, 7'b1000000); step(10);
    drive(4'b1100, 7'b1000000); step(10);
    check("badcom_pulses", n_upd - base, 0);
    check("badcom_num",    32'(num),   32'h8301);
    check("badcom_valid",  32'(valid), 32'b1101);
    check("badcom_err",    32'(err),   32'b0000);

    // Reset mid-hold discards the partial count.
    drive(4'b1110, 7'b0011001); step(2);
    rst = 1'b1;
    step(1);
    check("midrst_num",   32'(num),   32'h0);
    check("midrst_valid", 32'(valid), 32'h0);
    check("midrst_err",   32'(err),   32'h0);
    check("midrst_upd",   32'(upd),   32'h0);
    rst = 1'b0;
    base = n_upd;
    step(3);
    check("midrst_no_early", n_upd - base + 32'(upd), 0);
    step(1);
    check("midrst_upd_late", 32'(upd),      32'h1);
    check("midrst_num0",     32'(num[3:0]), 32'h4);
    check("midrst_valid2",   32'(valid),    32'b0001);
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
